// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
//   Shared definitions for the RV32M multiply/divide unit: funct3 opcodes,
//   the funct7 value that routes an R-type instruction to this unit, and
//   the FSM state encoding.
package muldiv_unit_pkg;

  // funct7 value identifying RV32M instructions
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // funct3 encodings for RV32M
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M multiply/divide execution unit. Multiplication is a
//   32-step shift-add on a 64-bit product register; division is a 32-step
//   restoring divide sharing the same register ({remainder, quotient}).
//   Both operate on operand magnitudes; the sign is applied in FIX.
//
// Ports
//   clk        core clock, rising edge
//   rst        asynchronous active-high reset
//   start      issue request, only sampled in IDLE
//   funct3     RV32M operation
//   ReadData1  rs1 (multiplicand / dividend)
//   ReadData2  rs2 (multiplier / divisor)
//   busy       operation in flight (MUL, DIV or FIX state)
//   done       one-cycle pulse, MDResult valid
//   MDResult   result, held until the next done
//
// Handshake: start is taken on the rising edge only while the unit is in
// IDLE; busy rises the cycle after acceptance and stays high through FIX;
// done pulses for one cycle with busy low; a start presented during busy or
// the done cycle is ignored, so the core re-presents it after done.
//
// Configuration
//   MULDIV_FAST_MUL_EN  when defined, the MUL state computes the whole
//                       product in one cycle; divide is unchanged.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  output logic        busy,
  output logic        done,
  output logic [31:0] MDResult
);

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic        neg_res_q, neg_res_d;   // product / quotient negate
  logic        neg_rem_q, neg_rem_d;   // remainder negate
  logic [31:0] a_q, a_d;               // multiplicand or divisor magnitude
  logic [63:0] prod_q, prod_d;         // product, or {remainder, quotient}
  logic [4:0]  count_q, count_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] md_result_q, md_result_d;

  // ---------------------------------------------------------------------
  // Issue-time operand decode
  // ---------------------------------------------------------------------
  logic        in_is_div;
  logic        in_sign1, in_sign2;
  logic [31:0] abs1, abs2;
  logic        div_by_zero, div_overflow;

  assign in_is_div = funct3[2];
  // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM
  assign in_sign1  = ReadData1[31] &&
                     ((funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV)  || (funct3 == F3_REM));
  assign in_sign2  = ReadData2[31] &&
                     ((funct3 == F3_MULH) || (funct3 == F3_DIV) ||
                      (funct3 == F3_REM));
  // magnitude of 0x80000000 stays 0x80000000, which is correct unsigned
  assign abs1 = in_sign1 ? (~ReadData1 + 32'd1) : ReadData1;
  assign abs2 = in_sign2 ? (~ReadData2 + 32'd1) : ReadData2;

  assign div_by_zero  = in_is_div && (ReadData2 == 32'd0);
  assign div_overflow = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                        (ReadData1 == 32'h8000_0000) &&
                        (ReadData2 == 32'hFFFF_FFFF);

  // ---------------------------------------------------------------------
  // Iteration and fix-up datapath
  // ---------------------------------------------------------------------
`ifndef MULDIV_FAST_MUL_EN
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, prod_q[63:32]} + {1'b0, a_q};
`endif

  // Trial subtraction of divisor from the shifted partial remainder;
  // bit 33 set means the trial went negative (restore).
  logic [33:0] div_diff;
  assign div_diff = {1'b0, prod_q[63:31]} - {2'b00, a_q};

  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  assign prod_fix = neg_res_q ? (~prod_q + 64'd1) : prod_q;
  assign quo_fix  = neg_res_q ? (~prod_q[31:0] + 32'd1) : prod_q[31:0];
  assign rem_fix  = neg_rem_q ? (~prod_q[63:32] + 32'd1) : prod_q[63:32];

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    a_d         = a_q;
    prod_d      = prod_q;
    count_d     = count_q;
    md_result_d = md_result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d      = funct3;
          count_d   = 5'd0;
          neg_res_d = in_sign1 ^ in_sign2;
          neg_rem_d = in_sign1;
          if (in_is_div) begin
            a_d     = abs2;
            prod_d  = {32'd0, abs1};
            state_d = ST_DIV;
            // Special cases preload the final {rem, quo} unsigned and
            // skip straight to FIX with negation disabled.
            if (div_by_zero) begin
              prod_d    = {ReadData1, 32'hFFFF_FFFF};
              neg_res_d = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = ST_FIX;
            end else if (div_overflow) begin
              prod_d    = {32'd0, 32'h8000_0000};
              neg_res_d = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = ST_FIX;
            end
          end else begin
            a_d     = abs1;
            prod_d  = {32'd0, abs2};
            state_d = ST_MUL;
          end
        end
      end

      ST_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
        // Magnitude product; sign applied in FIX exactly as in the
        // iterative build, so results are bit-identical.
        prod_d  = 64'(a_q) * 64'(prod_q[31:0]);
        state_d = ST_FIX;
`else
        // Multiplier sits in the low half and is shifted out LSB first.
        if (prod_q[0]) begin
          prod_d = {mul_sum, prod_q[31:1]};
        end else begin
          prod_d = {1'b0, prod_q[63:1]};
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          count_d = 5'd0;
          state_d = ST_FIX;
        end
`endif
      end

      ST_DIV: begin
        if (!div_diff[33]) begin
          prod_d = {div_diff[31:0], prod_q[30:0], 1'b1};
        end else begin
          prod_d = {prod_q[62:0], 1'b0};
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          count_d = 5'd0;
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        if (op_q[2]) begin
          // DIV/DIVU have op[1]=0, REM/REMU have op[1]=1
          md_result_d = op_q[1] ? rem_fix : quo_fix;
        end else begin
          md_result_d = (op_q == F3_MUL) ? prod_fix[31:0] : prod_fix[63:32];
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_MUL) || (state_d == ST_DIV) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'd0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      a_q         <= 32'd0;
      prod_q      <= 64'd0;
      count_q     <= 5'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      md_result_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      a_q         <= a_d;
      prod_q      <= prod_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      md_result_q <= md_result_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign MDResult = md_result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit: directed vector table, hand-written
//   reset / operand-toggle / back-to-back sequences, and randomized ops
//   checked against a plain-arithmetic reference model.
//   Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int BUDGET = 100;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] ReadData1, ReadData2;
  logic        busy, done;
  logic [31:0] MDResult;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .busy      (busy),
    .done      (done),
    .MDResult  (MDResult)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Scoreboard counters and compare helpers
  // ---------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model (plain 64-bit arithmetic)
  // ---------------------------------------------------------------------
  function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, sub;
    logic [63:0] ua, ub, p;
    int si, sj;
    sa  = $signed({{32{a[31]}}, a});
    sb  = $signed({{32{b[31]}}, b});
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    sub = $signed(ub);
    si  = a;
    sj  = b;
    case (f3)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * sub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return si / sj;
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return si % sj;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Cycles from the start cycle to the done cycle
  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3[2]) begin
      if (b == 32'd0) return 2;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 34;
    end
    return MUL_LAT;
  endfunction

  // ---------------------------------------------------------------------
  // Driver: issue one op, wait for done (bounded), report result/timing.
  // With scramble set, start/funct3/operands are randomised while busy.
  // ---------------------------------------------------------------------
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, output logic [31:0] res,
                        output int lat, output int bcnt);
    res  = 32'd0;
    lat  = 0;
    bcnt = 0;
    @(negedge clk);
    funct3 = f3; ReadData1 = a; ReadData2 = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        res = MDResult;
        break;
      end
      if (scramble) begin
        start     = 1'($urandom_range(0, 1));
        funct3    = 3'($urandom_range(0, 7));
        ReadData1 = $urandom;
        ReadData2 = $urandom;
      end
    end
    start = 1'b0;
  endtask

  task automatic op_and_check(input string tag, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp, input bit scramble);
    logic [31:0] res;
    int lat, bcnt, el;
    el = exp_lat(f3, a, b);
    run_op(f3, a, b, scramble, res, lat, bcnt);
    check32({tag, " result"}, res, exp);
    check_int({tag, " latency"}, lat, el);
    check_int({tag, " busy cycles"}, bcnt, el - 1);
  endtask

  // ---------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [31:0] res1, res2, ra, rb;
    logic [2:0]  rf;
    int lat, bcnt, el1, el2, sel;
    bit seen;

    tbl[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    tbl[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tbl[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    tbl[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    tbl[6]  = '{3'b101, 32'd100,       32'd7,         32'd14};
    tbl[7]  = '{3'b111, 32'd100,       32'd7,         32'd2};
    tbl[8]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF};
    tbl[9]  = '{3'b110, 32'd5,         32'd0,         32'd5};
    tbl[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    tbl[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    tbl[12] = '{3'b000, 32'd3,         32'd4,         32'd12};
    tbl[13] = '{3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF};
    tbl[14] = '{3'b111, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
    tbl[15] = '{3'b001, 32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFFF};

    // reset
    rst = 1'b1; start = 1'b0; funct3 = 3'd0; ReadData1 = 32'd0; ReadData2 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("reset busy", int'(busy), 0);
    check_int("reset done", int'(done), 0);
    check32("reset MDResult", MDResult, 32'd0);
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 16; i++) begin
      op_and_check($sformatf("vec%0d f3=%0d", i, tbl[i].f3), tbl[i].f3, tbl[i].a, tbl[i].b,
                   tbl[i].exp, 1'b0);
    end

    // result held after the done pulse, and done is a single cycle
    op_and_check("hold op", 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    @(negedge clk);
    check_int("done single pulse", int'(done), 0);
    repeat (3) @(negedge clk);
    check32("MDResult hold", MDResult, 32'hFFFF_FFEB);

    // reset in the middle of a DIV (iteration 10)
    @(negedge clk);
    funct3 = 3'b100; ReadData1 = 32'h1234_5678; ReadData2 = 32'h13; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check_int("mid-div busy before reset", int'(busy), 1);
    rst = 1'b1;
    #1;
    check_int("mid-div reset busy", int'(busy), 0);
    check_int("mid-div reset done", int'(done), 0);
    check32("mid-div reset MDResult", MDResult, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    op_and_check("mul after reset", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0);

    // inputs toggled while busy must not disturb the latched op
    op_and_check("scramble div", 3'b100, 32'hFFFF_FC00, 32'd33,
                 ref_result(3'b100, 32'hFFFF_FC00, 32'd33), 1'b1);
    op_and_check("scramble mulh", 3'b001, 32'hDEAD_BEEF, 32'h1234_5678,
                 ref_result(3'b001, 32'hDEAD_BEEF, 32'h1234_5678), 1'b1);

    // back-to-back with start held high: second op is taken from IDLE
    el1 = exp_lat(3'b101, 32'd100, 32'd7);
    el2 = exp_lat(3'b000, 32'd7, 32'hFFFF_FFFD);
    @(negedge clk);
    funct3 = 3'b101; ReadData1 = 32'd100; ReadData2 = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    funct3 = 3'b000; ReadData1 = 32'd7; ReadData2 = 32'hFFFF_FFFD;
    lat = 0; res1 = 32'd0; seen = 1'b0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      if (done) begin lat = k; res1 = MDResult; seen = 1'b1; break; end
    end
    check_int("b2b first latency", lat, el1);
    check32("b2b first result", res1, 32'd14);
    if (seen) begin
      @(negedge clk);
      check_int("b2b idle gap busy", int'(busy), 0);
      check_int("b2b idle gap done", int'(done), 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 0; res2 = 32'd0;
      for (int k = 1; k <= BUDGET; k++) begin
        @(negedge clk);
        if (done) begin lat = k; res2 = MDResult; break; end
      end
      check_int("b2b second latency", lat, el2);
      check32("b2b second result", res2, 32'hFFFF_FFEB);
    end
    start = 1'b0;

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rf  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      ra  = (sel == 9) ? 32'h8000_0000 : $urandom;
      sel = $urandom_range(0, 9);
      rb  = (sel == 0) ? 32'd0 :
            (sel == 1) ? 32'hFFFF_FFFF :
            (sel == 2) ? 32'($urandom_range(1, 15)) : $urandom;
      run_op(rf, ra, rb, 1'b0, res1, lat, bcnt);
      check32($sformatf("rand%0d f3=%0d a=%08h b=%08h result", i, rf, ra, rb),
              res1, ref_result(rf, ra, rb));
      check_int($sformatf("rand%0d latency", i), lat, exp_lat(rf, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
